// File: rtl/core_ifetch_resp_if.sv
// Fetch-response bundle: PC-logic request, instruction-memory req/gnt/rvalid bus and decode handshake.
// Defining CORE_IFETCH_ERR_EN adds the mem_err_i / instr_err_o sideband.
interface core_ifetch_resp_if #(
  parameter int XLEN = 32
);
  logic            fetch_req_i;
  logic [XLEN-1:0] fetch_addr_i;
  logic            fetch_gnt_o;
  logic            flush_i;
  logic            mem_req_o;
  logic [XLEN-1:0] mem_addr_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;
  logic            instr_valid_o;
  logic [XLEN-1:0] instr_o;
  logic [XLEN-1:0] instr_pc_o;
  logic            instr_ready_i;
`ifdef CORE_IFETCH_ERR_EN
  logic            mem_err_i;
  logic            instr_err_o;
`endif

  // Fetch-response block side.
  modport slave (
    input  fetch_req_i, fetch_addr_i, flush_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, instr_ready_i,
`ifdef CORE_IFETCH_ERR_EN
    input  mem_err_i,
    output instr_err_o,
`endif
    output fetch_gnt_o, mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o
  );

  // Environment side: PC logic, instruction memory and decode.
  modport master (
    output fetch_req_i, fetch_addr_i, flush_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, instr_ready_i,
`ifdef CORE_IFETCH_ERR_EN
    output mem_err_i,
    input  instr_err_o,
`endif
    input  fetch_gnt_o, mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o
  );
endinterface

// File: rtl/core_ifetch_resp.sv
// IF-stage response side: issues fetches on a req/gnt/rvalid bus, pairs in-order responses with their
// PCs in a FWFT FIFO for decode, and discards pre-flush responses. Error sideband under CORE_IFETCH_ERR_EN.
module core_ifetch_resp #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  core_ifetch_resp_if.slave bus
);
  localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW      = PW + 1;
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  typedef struct packed {
`ifdef CORE_IFETCH_ERR_EN
    logic            err;
`endif
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_fifo_cnt;
  logic [CW-1:0]   r_discard_cnt;
  logic [PW-1:0]   r_pcq_wptr;
  logic [PW-1:0]   r_pcq_rptr;
  logic [PW-1:0]   r_fifo_wptr;
  logic [PW-1:0]   r_fifo_rptr;
  logic [XLEN-1:0] r_pcq_mem  [DEPTH];
  entry_t          r_fifo_mem [DEPTH];

  logic            w_credit;
  logic            w_mem_req;
  logic            w_gnt;
  logic            w_rvalid_ok;
  logic            w_drop;
  logic            w_fifo_push;
  logic            w_fifo_pop;
  logic            w_instr_valid;
  logic [CW:0]     w_in_use;
  logic [CW-1:0]   w_outstanding_nxt;
  entry_t          w_push_entry;
  entry_t          w_head;

  // Discarded-but-pending responses still hold credit: their slots are only freed when they return.
  assign w_in_use          = {1'b0, r_outstanding} + {1'b0, r_fifo_cnt};
  assign w_credit          = w_in_use < DEPTH_W;
  assign w_mem_req         = bus.fetch_req_i & w_credit & ~bus.flush_i;
  assign w_gnt             = w_mem_req & bus.mem_gnt_i;
  // An rvalid with nothing outstanding (protocol error or a leftover from before reset) is ignored.
  assign w_rvalid_ok       = bus.mem_rvalid_i & (r_outstanding != '0);
  assign w_drop            = w_rvalid_ok & (r_discard_cnt != '0);
  assign w_fifo_push       = w_rvalid_ok & ~w_drop & ~bus.flush_i;
  assign w_instr_valid     = (r_fifo_cnt != '0);
  assign w_fifo_pop        = w_instr_valid & bus.instr_ready_i;
  assign w_outstanding_nxt = r_outstanding + CW'(w_gnt) - CW'(w_rvalid_ok);

  always_comb begin
    // NOTE: assign a default first so every path drives every field and no latch is inferred.
    w_push_entry       = '0;
    w_push_entry.pc    = r_pcq_mem[r_pcq_rptr];
    w_push_entry.instr = bus.mem_rdata_i;
`ifdef CORE_IFETCH_ERR_EN
    w_push_entry.err   = bus.mem_err_i;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outstanding <= '0;
      r_discard_cnt <= '0;
      r_pcq_wptr    <= '0;
      r_pcq_rptr    <= '0;
      r_fifo_cnt    <= '0;
      r_fifo_wptr   <= '0;
      r_fifo_rptr   <= '0;
    end else begin
      r_outstanding <= w_outstanding_nxt;
      if (w_gnt)       r_pcq_wptr <= r_pcq_wptr + PW'(1);
      if (w_rvalid_ok) r_pcq_rptr <= r_pcq_rptr + PW'(1);

      // No grant can happen in a flush cycle, so whatever is still in flight after it is pre-flush.
      if (bus.flush_i)  r_discard_cnt <= w_outstanding_nxt;
      else if (w_drop)  r_discard_cnt <= r_discard_cnt - CW'(1);

      if (bus.flush_i) begin
        r_fifo_cnt  <= '0;
        r_fifo_wptr <= '0;
        r_fifo_rptr <= '0;
      end else begin
        if (w_fifo_push) r_fifo_wptr <= r_fifo_wptr + PW'(1);
        if (w_fifo_pop)  r_fifo_rptr <= r_fifo_rptr + PW'(1);
        r_fifo_cnt <= r_fifo_cnt + CW'(w_fifo_push) - CW'(w_fifo_pop);
      end
    end
  end

  // NOTE: storage arrays are not reset; the counters mark live entries and outputs are gated by valid.
  always_ff @(posedge clk_i) begin
    if (w_gnt)       r_pcq_mem[r_pcq_wptr]   <= bus.fetch_addr_i;
    if (w_fifo_push) r_fifo_mem[r_fifo_wptr] <= w_push_entry;
  end

  assign w_head            = r_fifo_mem[r_fifo_rptr];
  assign bus.mem_req_o     = w_mem_req;
  assign bus.mem_addr_o    = bus.fetch_addr_i;
  assign bus.fetch_gnt_o   = w_gnt;
  assign bus.instr_valid_o = w_instr_valid;
  assign bus.instr_o       = w_instr_valid ? w_head.instr : '0;
  assign bus.instr_pc_o    = w_instr_valid ? w_head.pc    : '0;
`ifdef CORE_IFETCH_ERR_EN
  assign bus.instr_err_o   = w_instr_valid & w_head.err;
`endif

endmodule

// File: tb/tb_core_ifetch_resp.sv
// Self-checking bench for core_ifetch_resp: directed vector table, multi-cycle corner sequences and
// randomized traffic against a queue-based reference model. Honors CORE_IFETCH_ERR_EN.
module tb_core_ifetch_resp;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] A     = 32'h1000_0000;
  localparam logic [31:0] B     = 32'h1000_0020;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  core_ifetch_resp_if #(.XLEN(XLEN)) bus ();
  core_ifetch_resp #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        flush;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        ready;
  } in_t;

  typedef struct {
    in_t         i;
    logic        mem_req;
    logic        fgnt;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  // Reference model: requests in flight (with a killed mark) and buffered {pc, instr, err} results.
  typedef struct { logic [31:0] pc; bit killed; } fly_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic err; } out_t;
  fly_t m_fly[$];
  out_t m_out[$];

  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(logic req, logic [31:0] addr, logic flush, logic gnt,
                             logic rvalid, logic [31:0] rdata, logic ready);
    in_t v;
    v.req = req; v.addr = addr; v.flush = flush; v.gnt = gnt;
    v.rvalid = rvalid; v.rdata = rdata; v.err = 1'b0; v.ready = ready;
    return v;
  endfunction

  task automatic apply(input in_t v);
    bus.fetch_req_i   = v.req;
    bus.fetch_addr_i  = v.addr;
    bus.flush_i       = v.flush;
    bus.mem_gnt_i     = v.gnt;
    bus.mem_rvalid_i  = v.rvalid;
    bus.mem_rdata_i   = v.rdata;
    bus.instr_ready_i = v.ready;
`ifdef CORE_IFETCH_ERR_EN
    bus.mem_err_i     = v.err;
`endif
  endtask

  task automatic model_step(input in_t v);
    bit   gnt;
    fly_t f;
    gnt = v.req && ((m_fly.size() + m_out.size()) < DEPTH) && !v.flush && v.gnt;
    if (m_out.size() != 0 && v.ready) void'(m_out.pop_front());
    if (v.rvalid && m_fly.size() != 0) begin
      f = m_fly.pop_front();
      if (!f.killed && !v.flush) m_out.push_back(out_t'{f.pc, v.rdata, v.err});
    end
    if (v.flush) begin
      foreach (m_fly[k]) m_fly[k].killed = 1'b1;
      m_out.delete();
    end
    if (gnt) m_fly.push_back(fly_t'{v.addr, 1'b0});
  endtask

  // One cycle of stimulus checked against the model, then the model advances with the clock edge.
  task automatic run_cycle(input in_t v);
    logic exp_req;
    logic exp_valid;
    out_t head;
    apply(v);
    @(negedge clk);
    exp_valid = (m_out.size() != 0);
    exp_req   = v.req && ((m_fly.size() + m_out.size()) < DEPTH) && !v.flush;
    head      = out_t'{32'h0, 32'h0, 1'b0};
    if (exp_valid) head = m_out[0];
    check("mem_req_o", {31'b0, bus.mem_req_o}, {31'b0, exp_req});
    check("fetch_gnt_o", {31'b0, bus.fetch_gnt_o}, {31'b0, exp_req & v.gnt});
    check("mem_addr_o", bus.mem_addr_o, v.addr);
    check("instr_valid_o", {31'b0, bus.instr_valid_o}, {31'b0, exp_valid});
    if (exp_valid) begin
      check("instr_pc_o", bus.instr_pc_o, head.pc);
      check("instr_o", bus.instr_o, head.instr);
    end
`ifdef CORE_IFETCH_ERR_EN
    check("instr_err_o", {31'b0, bus.instr_err_o}, {31'b0, head.err});
`endif
    @(posedge clk);
    #1;
    model_step(v);
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    apply(t.i);
    @(negedge clk);
    check($sformatf("vec%0d.mem_req_o", idx), {31'b0, bus.mem_req_o}, {31'b0, t.mem_req});
    check($sformatf("vec%0d.fetch_gnt_o", idx), {31'b0, bus.fetch_gnt_o}, {31'b0, t.fgnt});
    check($sformatf("vec%0d.instr_valid_o", idx), {31'b0, bus.instr_valid_o}, {31'b0, t.valid});
    if (t.valid) begin
      check($sformatf("vec%0d.instr_pc_o", idx), bus.instr_pc_o, t.pc);
      check($sformatf("vec%0d.instr_o", idx), bus.instr_o, t.instr);
    end
    @(posedge clk);
    #1;
    model_step(t.i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t v;
    in_t idle;
    idle = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Back-to-back fetch with DEPTH=2: a buffered entry holds credit until it leaves.
    tbl[0]  = '{mk(1, A,     0, 1, 0, 32'h0,         1), 1, 1, 0, 32'h0,  32'h0};
    tbl[1]  = '{mk(1, A+4,   0, 1, 1, 32'h1111_0000, 1), 1, 1, 0, 32'h0,  32'h0};
    tbl[2]  = '{mk(1, A+8,   0, 1, 1, 32'h1111_0004, 1), 0, 0, 1, A,      32'h1111_0000};
    tbl[3]  = '{mk(1, A+8,   0, 1, 0, 32'h0,         1), 1, 1, 1, A+4,    32'h1111_0004};
    tbl[4]  = '{mk(0, 32'h0, 0, 0, 1, 32'h1111_0008, 1), 0, 0, 0, 32'h0,  32'h0};
    tbl[5]  = '{mk(0, 32'h0, 0, 0, 0, 32'h0,         1), 0, 0, 1, A+8,    32'h1111_0008};
    tbl[6]  = '{mk(0, 32'h0, 0, 0, 0, 32'h0,         1), 0, 0, 0, 32'h0,  32'h0};
    // Backpressure: two grants fill the credit, one pop lets issue resume.
    tbl[7]  = '{mk(1, B,     0, 1, 0, 32'h0,         0), 1, 1, 0, 32'h0,  32'h0};
    tbl[8]  = '{mk(1, B+4,   0, 1, 1, 32'h2222_0000, 0), 1, 1, 0, 32'h0,  32'h0};
    tbl[9]  = '{mk(1, B+8,   0, 1, 1, 32'h2222_0004, 0), 0, 0, 1, B,      32'h2222_0000};
    tbl[10] = '{mk(1, B+8,   0, 1, 0, 32'h0,         0), 0, 0, 1, B,      32'h2222_0000};
    tbl[11] = '{mk(1, B+8,   0, 1, 0, 32'h0,         1), 0, 0, 1, B,      32'h2222_0000};
    tbl[12] = '{mk(1, B+8,   0, 1, 0, 32'h0,         0), 1, 1, 1, B+4,    32'h2222_0004};
    tbl[13] = '{mk(0, 32'h0, 0, 0, 1, 32'h2222_0008, 1), 0, 0, 1, B+4,    32'h2222_0004};
    tbl[14] = '{mk(0, 32'h0, 0, 0, 0, 32'h0,         1), 0, 0, 1, B+8,    32'h2222_0008};
    tbl[15] = '{mk(0, 32'h0, 0, 0, 0, 32'h0,         1), 0, 0, 0, 32'h0,  32'h0};

    rst_n = 1'b0;
    apply(mk(0, 32'h0, 0, 0, 0, 32'h0, 0));
    repeat (2) @(posedge clk);
    #1;
    check("reset.instr_valid_o", {31'b0, bus.instr_valid_o}, 32'h0);
    check("reset.instr_o", bus.instr_o, 32'h0);
    check("reset.instr_pc_o", bus.instr_pc_o, 32'h0);
    check("reset.mem_req_o", {31'b0, bus.mem_req_o}, 32'h0);
    check("reset.fetch_gnt_o", {31'b0, bus.fetch_gnt_o}, 32'h0);
`ifdef CORE_IFETCH_ERR_EN
    check("reset.instr_err_o", {31'b0, bus.instr_err_o}, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 16; k++) run_vec(tbl[k], k);

    // Flush with two outstanding: both late responses dropped, the post-flush fetch comes out first.
    run_cycle(mk(1, A,   0, 1, 0, 32'h0, 1));
    run_cycle(mk(1, A+4, 0, 1, 0, 32'h0, 1));
    v = mk(1, A+32'h40, 1, 1, 0, 32'h0, 1);
    apply(v);
    #2;
    check("flush.mem_req_o", {31'b0, bus.mem_req_o}, 32'h0);
    run_cycle(v);
    run_cycle(mk(1, A+32'h40, 0, 1, 1, 32'h3333_0000, 1));
    check("flush.drop0", {31'b0, bus.instr_valid_o}, 32'h0);
    run_cycle(mk(1, A+32'h40, 0, 1, 1, 32'h3333_0004, 1));
    check("flush.drop1", {31'b0, bus.instr_valid_o}, 32'h0);
    run_cycle(mk(0, 32'h0, 0, 0, 1, 32'h3333_0040, 0));
    check("flush.first_pc", bus.instr_pc_o, A+32'h40);
    check("flush.first_instr", bus.instr_o, 32'h3333_0040);
    run_cycle(idle);

    // Flush in the same cycle as the only outstanding response: nothing left to discard afterwards.
    run_cycle(mk(1, A+32'h100, 0, 1, 0, 32'h0, 1));
    run_cycle(mk(0, 32'h0, 1, 0, 1, 32'h4444_0000, 1));
    check("flush_rvalid.valid", {31'b0, bus.instr_valid_o}, 32'h0);
    run_cycle(mk(1, A+32'h80, 0, 1, 0, 32'h0, 1));
    run_cycle(mk(0, 32'h0, 0, 0, 1, 32'h4444_0080, 0));
    check("flush_rvalid.next_pc", bus.instr_pc_o, A+32'h80);
    run_cycle(idle);

    // Stalling memory: requests held without grant never enter the PC queue.
    for (int k = 0; k < 5; k++) begin
      v = mk(1, A+32'h200+32'(4*k), 0, 0, 0, 32'h0, 1);
      apply(v);
      #2;
      check("stall.mem_addr_o", bus.mem_addr_o, A+32'h200+32'(4*k));
      check("stall.fetch_gnt_o", {31'b0, bus.fetch_gnt_o}, 32'h0);
      run_cycle(v);
    end
    run_cycle(mk(1, A+32'h300, 0, 1, 0, 32'h0, 1));
    run_cycle(mk(0, 32'h0, 0, 0, 1, 32'h5555_0300, 0));
    check("stall.pc", bus.instr_pc_o, A+32'h300);
    run_cycle(idle);

    // Reset with one outstanding and one buffered fetch.
    run_cycle(mk(1, A+32'h400, 0, 1, 0, 32'h0, 0));
    run_cycle(mk(1, A+32'h404, 0, 1, 1, 32'h6666_0400, 0));
    check("pre_reset.valid", {31'b0, bus.instr_valid_o}, 32'h1);
    apply(mk(0, 32'h0, 0, 0, 0, 32'h0, 0));
    rst_n = 1'b0;
    #1;
    check("mid_reset.valid", {31'b0, bus.instr_valid_o}, 32'h0);
    check("mid_reset.pc", bus.instr_pc_o, 32'h0);
    m_fly.delete();
    m_out.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_cycle(mk(0, 32'h0, 0, 0, 1, 32'h7777_0404, 1));
    check("late_rvalid.valid", {31'b0, bus.instr_valid_o}, 32'h0);
    run_cycle(mk(1, A, 0, 1, 0, 32'h0, 1));
    v = mk(0, 32'h0, 0, 0, 1, 32'h7777_0000, 0);
    v.err = 1'b1;
    run_cycle(v);
    check("post_reset.pc", bus.instr_pc_o, A);
    check("post_reset.instr", bus.instr_o, 32'h7777_0000);
`ifdef CORE_IFETCH_ERR_EN
    check("post_reset.err", {31'b0, bus.instr_err_o}, 32'h1);
`endif
    run_cycle(idle);

    // Randomized traffic; responses only for requests the model holds in flight.
    for (int c = 0; c < 3000; c++) begin
      v.req    = ($urandom_range(0, 3) != 0);
      v.addr   = $urandom() & 32'hFFFF_FFFC;
      v.flush  = ($urandom_range(0, 19) == 0);
      v.gnt    = ($urandom_range(0, 2) != 0);
      v.rvalid = (m_fly.size() != 0) && ($urandom_range(0, 2) != 0);
      v.rdata  = $urandom();
      v.err    = 1'($urandom_range(0, 1));
      v.ready  = ($urandom_range(0, 3) != 0);
      run_cycle(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
